fv_op_sched: RTL and testbench

- Round-robin scheduler sharing one small bitwise/reduction operator unit (AND, OR, reduce-AND, equality on W-bit operands) among NREQ requesters.
- Each requester issues an op and operands through a valid/ready handshake.
- The block grants one request at a time, executes it on the shared operator, and returns the result tagged with the requester id through a valid/ready response port.
- Sits between local FSMs and the shared logic datapath; it is the only owner of that datapath.

---
 rtl/fv_op_pkg.sv | 23 ++
 rtl/fv_rr_pick.sv | 41 ++++
 rtl/fv_op_sched.sv | 135 +++++++++++++
 tb/tb_fv_op_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fv_op_pkg.sv
// fv_op_pkg
// Shared definitions for the operator scheduler: op codes understood by
// the shared bitwise/reduction unit, the scheduler FSM state encoding and
// the default operand width.
package fv_op_pkg;

  // Op codes carried on req_op
  localparam logic [1:0] OP_AND  = 2'b00;  // A & B
  localparam logic [1:0] OP_OR   = 2'b01;  // A | B
  localparam logic [1:0] OP_RAND = 2'b10;  // reduce-AND of A, zero-extended
  localparam logic [1:0] OP_EQ   = 2'b11;  // A == B, zero-extended

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // Default operand/result width
  localparam int DEF_W = 3;

endpackage

// File: rtl/fv_rr_pick.sv
// fv_rr_pick
// Combinational round-robin picker. Searches the request vector starting
// one position above the pointer and wrapping modulo NREQ; the first set
// bit wins.
//
// Ports:
//   i_req    NREQ-bit request vector
//   i_ptr    index of the last winner (search starts at i_ptr+1)
//   o_grant  one-hot grant, zero when no request is set
//   o_idx    binary index of the winner (0 when no request)
//   o_any    at least one request is set
module fv_rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  always_comb begin
    int w_cand;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    // Distance 1 is the highest-priority position, distance NREQ (the
    // pointer itself) the lowest.
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[w_cand]) begin
        o_any   = 1'b1;
        o_idx   = IDW'(w_cand);
        o_grant = {{(NREQ-1){1'b0}}, 1'b1} << w_cand;
      end
    end
  end

endmodule

// File: rtl/fv_op_sched.sv
// fv_op_sched
// Round-robin scheduler owning one shared bitwise/reduction operator.
// Accepts one request at a time (IDLE), evaluates it from captured
// registers (EXEC), and presents the tagged result until the consumer
// takes it (HOLD).
//
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   req_valid/ready    per-requester handshake; ready is one-hot or zero
//   req_op/a/b         packed per-requester op code and operands
//   rsp_valid/ready    result handshake
//   rsp_id, rsp_data   requester index and result of the held response
//   busy               high whenever the FSM is not IDLE
module fv_op_sched
  import fv_op_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = DEF_W,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy
);

  // Shared operator: everything is W bits wide with no carries; the
  // reduce and compare results live in bit 0.
  function automatic logic [W-1:0] f_op(input logic [1:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W-1:0] res;
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_RAND: res[0] = &a;
      OP_EQ:   res[0] = (a == b);
      default: res = '0;
    endcase
    return res;
  endfunction

  state_t          r_state;
  state_t          w_state_next;
  logic [IDW-1:0]  r_ptr;
  logic [1:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [IDW-1:0]  r_id;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [W-1:0]    r_rsp_data;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_accept;
  logic [W-1:0]    w_result;

  fv_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_accept = (r_state == ST_IDLE) && w_any;
  assign w_result = f_op(r_op, r_a, r_b);

  // Next state and the combinational grant
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = w_grant;
        if (w_any) w_state_next = ST_EXEC;
      end
      ST_EXEC: w_state_next = ST_HOLD;
      ST_HOLD: if (r_rsp_valid && rsp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // Pointer starts at the top so requester 0 is searched first
      r_ptr       <= IDW'(NREQ - 1);
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= req_op[2*int'(w_idx) +: 2];
        r_a   <= req_a[W*int'(w_idx) +: W];
        r_b   <= req_b[W*int'(w_idx) +: W];
        r_id  <= w_idx;
        r_ptr <= w_idx;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_result;
        r_rsp_id    <= r_id;
      end else if (r_state == ST_HOLD && rsp_ready) begin
        // Result registers keep their last value after the handshake
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fv_op_sched.sv
// Self-checking bench for fv_op_sched (NREQ=4, W=3): directed scenarios
// followed by randomized transactions checked against a transaction-level
// reference model (round-robin search over a mask, op rules as arithmetic).
module tb_fv_op_sched;

  localparam int NREQ = 4;
  localparam int W    = 3;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [3:0]      req_valid = '0;
  logic [3:0]      req_ready;
  logic [7:0]      req_op = '0;
  logic [11:0]     req_a = '0;
  logic [11:0]     req_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_id;
  logic [2:0]      rsp_data;
  logic            busy;

  fv_op_sched #(.NREQ(NREQ), .W(W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int mptr  = NREQ - 1;   // model's record of the last winner

  logic [1:0] t_op [4];
  logic [2:0] t_a  [4];
  logic [2:0] t_b  [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_op(input logic [1:0] op, input logic [2:0] a,
                                        input logic [2:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return (a == 3'b111) ? 3'd1 : 3'd0;
      default: return (a == b) ? 3'd1 : 3'd0;
    endcase
  endfunction

  // First set bit after the last winner, wrapping around
  function automatic int model_pick(input logic [3:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (mptr + k) % NREQ;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    req_op = {t_op[3], t_op[2], t_op[1], t_op[0]};
    req_a  = {t_a[3],  t_a[2],  t_a[1],  t_a[0]};
    req_b  = {t_b[3],  t_b[2],  t_b[1],  t_b[0]};
  endtask

  // One full transaction. Entered and left 1 time unit after a rising edge
  // with the DUT in IDLE and rsp_ready low. keep_valid leaves the request
  // mask asserted through EXEC/HOLD to show no further grant is given.
  task automatic txn(input logic [3:0] mask, input int hold, input bit keep_valid);
    int w;
    logic [2:0] exp;
    drive_ops();
    req_valid = mask;
    w   = model_pick(mask);
    exp = ref_op(t_op[w], t_a[w], t_b[w]);
    #1;
    chk("idle_ready", req_ready, 32'(1) << w);
    chk("idle_busy", busy, 0);
    @(posedge CLK); #1;
    if (!keep_valid) req_valid = '0;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_ready", req_ready, 0);
    @(posedge CLK); #1;
    chk("hold_rsp_valid", rsp_valid, 1);
    chk("hold_rsp_id", rsp_id, w);
    chk("hold_rsp_data", rsp_data, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, w);
      chk("bp_rsp_data", rsp_data, exp);
      chk("bp_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_rsp_id_kept", rsp_id, w);
    chk("done_rsp_data_kept", rsp_data, exp);
    mptr = w;
  endtask

  initial begin
    int rr_seq [5];
    int exp_q [$];
    int n_acc;
    int last_c;
    int w;

    rr_seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      t_op[i] = '0; t_a[i] = '0; t_b[i] = '0;
    end

    // Reset state
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    mptr = NREQ - 1;

    // Single request, requester 0: 110 & 011 = 010
    t_op[0] = 2'b00; t_a[0] = 3'b110; t_b[0] = 3'b011;
    txn(4'b0001, 0, 1'b0);
    chk("single_data", rsp_data, 3'b010);

    // Op coverage on requester 2
    t_op[2] = 2'b01; t_a[2] = 3'b100; t_b[2] = 3'b001;
    txn(4'b0100, 0, 1'b0);
    chk("op_or", rsp_data, 3'b101);
    t_op[2] = 2'b10; t_a[2] = 3'b111; t_b[2] = 3'b000;
    txn(4'b0100, 0, 1'b0);
    chk("op_rand_1", rsp_data, 3'b001);
    t_op[2] = 2'b10; t_a[2] = 3'b011; t_b[2] = 3'b011;
    txn(4'b0100, 0, 1'b0);
    chk("op_rand_0", rsp_data, 3'b000);
    t_op[2] = 2'b11; t_a[2] = 3'b101; t_b[2] = 3'b101;
    txn(4'b0100, 0, 1'b0);
    chk("op_eq", rsp_data, 3'b001);

    // Pointer wrap: 3, then 0, then 3
    t_op[0] = 2'b01; t_a[0] = 3'b001; t_b[0] = 3'b010;
    t_op[3] = 2'b00; t_a[3] = 3'b111; t_b[3] = 3'b101;
    txn(4'b1000, 0, 1'b0);
    chk("wrap_id_a", rsp_id, 3);
    txn(4'b1001, 0, 1'b0);
    chk("wrap_id_b", rsp_id, 0);
    txn(4'b1001, 0, 1'b0);
    chk("wrap_id_c", rsp_id, 3);

    // Round-robin with all requesters valid and rsp_ready held high
    for (int i = 0; i < 4; i++) begin
      t_op[i] = 2'(i); t_a[i] = 3'(i + 3); t_b[i] = 3'(7 - i);
    end
    drive_ops();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    n_acc = 0;
    last_c = -100;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (req_ready != 4'b0000) begin
        w = model_pick(4'hF);
        chk("rr_ready", req_ready, 32'(1) << w);
        if (n_acc < 5) chk("rr_order", w, rr_seq[n_acc]);
        if (n_acc > 0) chk("rr_gap", c - last_c, 3);
        last_c = c;
        n_acc++;
        mptr = w;
        exp_q.push_back(w);
      end
      if (rsp_valid) begin
        chk("rr_rsp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("rr_rsp_id", rsp_id, w);
          chk("rr_rsp_data", rsp_data, ref_op(t_op[w], t_a[w], t_b[w]));
        end
      end
      @(posedge CLK);
    end
    #1;
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("rr_accepts", n_acc, 5);
    chk("rr_drained", exp_q.size(), 0);

    // Backpressure: 5 cycles with rsp_ready low, requests kept asserted
    txn(4'hF, 5, 1'b1);
    chk("bp_next_id", rsp_id, 1);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        t_op[i] = 2'($urandom_range(0, 3));
        t_a[i]  = 3'($urandom_range(0, 7));
        t_b[i]  = ($urandom_range(0, 3) == 0) ? t_a[i] : 3'($urandom_range(0, 7));
      end
      txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset while holding a response
    t_op[2] = 2'b01; t_a[2] = 3'b010; t_b[2] = 3'b001;
    drive_ops();
    req_valid = 4'b0100;
    @(posedge CLK); #1;
    req_valid = '0;
    @(posedge CLK); #1;
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_data", rsp_data, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    mptr = NREQ - 1;
    for (int i = 0; i < 4; i++) begin
      t_op[i] = 2'b00; t_a[i] = 3'(i + 1); t_b[i] = 3'b111;
    end
    txn(4'hF, 0, 1'b0);
    chk("post_rst_id", rsp_id, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
